// File: rtl/hamming_dec_arb_pkg.sv
// Shared types for the ECC decoder scheduler: payload widths, requester ID, FSM states.
package hamming_dec_arb_pkg;

    localparam int unsigned PATTERN_W = 8;
    localparam int unsigned PARITY_W  = 4;
    localparam int unsigned NREQ_MAX  = 16;
    localparam int unsigned REQ_ID_W  = $clog2(NREQ_MAX);

    typedef logic [PATTERN_W-1:0] pattern_t;
    typedef logic [PARITY_W-1:0]  parity_t;
    typedef logic [REQ_ID_W-1:0]  req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // One stage of the in-flight tag pipeline.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/hamming_dec_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the pointer wins.
module rr_arbiter
    import hamming_dec_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]     i_req,
    input  logic [REQ_ID_W-1:0] i_ptr,
    output logic [NREQ-1:0]     o_grant_c,
    output logic [REQ_ID_W-1:0] o_id_c,
    output logic                o_valid_c
);

    // Scan offsets from the pointer; the first hit is granted.
    always_comb begin
        o_grant_c = '0;
        o_id_c    = '0;
        o_valid_c = 1'b0;
        for (int off = 0; off < int'(NREQ); off++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!o_valid_c && i_req[i] && (i == ((int'(i_ptr) + off) % int'(NREQ)))) begin
                    o_valid_c    = 1'b1;
                    o_grant_c[i] = 1'b1;
                    o_id_c       = REQ_ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hamming_dec_arb.sv
// Shares one Hamming decoder between NREQ requesters; tags each issue and routes parity back.
module hamming_dec_arb
    import hamming_dec_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DEC_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*PATTERN_W-1:0] i_req_pattern,
    output logic [NREQ-1:0]           o_req_ready,
    output logic                      o_dec_en,
    output logic [PATTERN_W-1:0]      o_dec_pattern,
    output logic                      o_dec_valid,
    input  logic [PARITY_W-1:0]       i_dec_parity,
    input  logic                      i_dec_valid,
    output logic [NREQ-1:0]           o_rsp_valid,
    output logic [REQ_ID_W-1:0]       o_rsp_id,
    output logic [PARITY_W-1:0]       o_rsp_parity,
    output logic                      o_busy,
    output logic                      o_err
);

    arb_state_e             state_q, state_d;
    req_id_t                rr_ptr_q, rr_ptr_d;
    logic                   iss_valid_q, iss_valid_d;
    req_id_t                iss_id_q, iss_id_d;
    pattern_t               dec_pattern_q, dec_pattern_d;
    tag_t [DEC_LAT-1:0]     tag_q, tag_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    req_id_t                rsp_id_q, rsp_id_d;
    parity_t                rsp_parity_q, rsp_parity_d;
    logic                   err_q, err_d;

    logic [NREQ-1:0]        arb_grant;
    req_id_t                arb_id;
    logic                   arb_valid;
    logic                   accept;
    pattern_t               acc_pattern;
    logic                   pipe_empty;
    tag_t                   head;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req     (i_req_valid),
        .i_ptr     (rr_ptr_q),
        .o_grant_c (arb_grant),
        .o_id_c    (arb_id),
        .o_valid_c (arb_valid)
    );

    // Grants only in RUN; a held reset blocks any transfer in the same cycle.
    assign o_req_ready = (state_q == RUN && i_rst_n) ? arb_grant : '0;
    assign accept      = arb_valid && (state_q == RUN) && i_rst_n;
    assign head        = tag_q[DEC_LAT-1];

    // Select the granted requester's pattern.
    always_comb begin
        acc_pattern = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_grant[i]) begin
                acc_pattern = i_req_pattern[i*PATTERN_W +: PATTERN_W];
            end
        end
    end

    // Nothing left in flight once the issue register and every tag stage are empty.
    always_comb begin
        pipe_empty = !iss_valid_q;
        for (int i = 0; i < int'(DEC_LAT); i++) begin
            if (tag_q[i].valid) begin
                pipe_empty = 1'b0;
            end
        end
    end

    // Scheduler FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_en) state_d = RUN;
            RUN:     if (!i_en) state_d = DRAIN;
            DRAIN: begin
                if (i_en) begin
                    state_d = RUN;
                end else if (pipe_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue register and round-robin pointer advance on an accepted transfer.
    always_comb begin
        iss_valid_d   = 1'b0;
        iss_id_d      = iss_id_q;
        dec_pattern_d = dec_pattern_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            iss_valid_d   = 1'b1;
            iss_id_d      = arb_id;
            dec_pattern_d = acc_pattern;
            if (32'(arb_id) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = arb_id + REQ_ID_W'(1);
            end
        end
    end

    // Tag pipeline shifts every cycle; the head is matched against the decoder's valid.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = iss_valid_q;
        tag_d[0].id    = iss_id_q;
        for (int i = 1; i < int'(DEC_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        rsp_valid_d  = '0;
        rsp_id_d     = rsp_id_q;
        rsp_parity_d = rsp_parity_q;
        err_d        = err_q;
        if (head.valid && i_dec_valid) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (head.id == REQ_ID_W'(i)) begin
                    rsp_valid_d[i] = 1'b1;
                end
            end
            rsp_id_d     = head.id;
            rsp_parity_d = i_dec_parity;
        end else if (head.valid != i_dec_valid) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            iss_valid_q   <= 1'b0;
            iss_id_q      <= '0;
            dec_pattern_q <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_id_q      <= '0;
            rsp_parity_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            iss_valid_q   <= iss_valid_d;
            iss_id_q      <= iss_id_d;
            dec_pattern_q <= dec_pattern_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_parity_q  <= rsp_parity_d;
            err_q         <= err_d;
        end
    end

    assign o_dec_en      = (state_q != IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_dec_valid   = iss_valid_q;
    assign o_dec_pattern = dec_pattern_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_id      = rsp_id_q;
    assign o_rsp_parity  = rsp_parity_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_hamming_dec_arb.sv
// Scoreboard bench for hamming_dec_arb with a fixed-latency decoder model.
module tb_hamming_dec_arb;
    import hamming_dec_arb_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DEC_LAT = 3;

    typedef struct {
        logic [7:0] pat;
        int         cyc;
    } iss_t;

    typedef struct {
        int         id;
        logic [3:0] par;
        int         cyc;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ*PATTERN_W-1:0] req_pattern;
    logic [NREQ-1:0]           req_ready;
    logic                      dec_en;
    logic [PATTERN_W-1:0]      dec_pattern;
    logic                      dec_valid_o;
    logic [PARITY_W-1:0]       dec_parity;
    logic                      dec_valid_i;
    logic [NREQ-1:0]           rsp_valid;
    logic [REQ_ID_W-1:0]       rsp_id;
    logic [PARITY_W-1:0]       rsp_parity;
    logic                      busy;
    logic                      err;
    logic                      inj;

    logic [DEC_LAT-1:0]        mdl_v;
    logic [PARITY_W-1:0]       mdl_p [DEC_LAT];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rsp_count = 0;
    int   last_rsp_cyc = 0;
    logic [7:0] last_pat = '0;
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   grant_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hamming_dec_arb #(.NREQ(NREQ), .DEC_LAT(DEC_LAT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_req_valid   (req_valid),
        .i_req_pattern (req_pattern),
        .o_req_ready   (req_ready),
        .o_dec_en      (dec_en),
        .o_dec_pattern (dec_pattern),
        .o_dec_valid   (dec_valid_o),
        .i_dec_parity  (dec_parity),
        .i_dec_valid   (dec_valid_i),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_id      (rsp_id),
        .o_rsp_parity  (rsp_parity),
        .o_busy        (busy),
        .o_err         (err)
    );

    function automatic logic [3:0] par_f(input logic [7:0] p);
        return {^(p & 8'hB5), ^(p & 8'h6B), ^(p & 8'hD3), ^(p & 8'h1E)};
    endfunction

    // Decoder model: DEC_LAT-cycle delay line from o_dec_valid to i_dec_valid.
    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_v <= '0;
            for (int i = 0; i < int'(DEC_LAT); i++) mdl_p[i] <= '0;
        end else begin
            mdl_v[0] <= dec_valid_o;
            mdl_p[0] <= par_f(dec_pattern);
            for (int i = 1; i < int'(DEC_LAT); i++) begin
                mdl_v[i] <= mdl_v[i-1];
                mdl_p[i] <= mdl_p[i-1];
            end
        end
    end
    assign dec_valid_i = mdl_v[DEC_LAT-1] | inj;
    assign dec_parity  = mdl_p[DEC_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: scoreboard compare of decoder issue and responses, then push new transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_pat = '0;
        end else begin
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                chk("dec_valid", 32'(dec_valid_o), 32'd1);
                chk("dec_pattern", 32'(dec_pattern), 32'(iss_q[0].pat));
                void'(iss_q.pop_front());
            end else begin
                if (dec_valid_o) chk("dec_spurious", 32'(dec_valid_o), 32'd0);
                if (dec_pattern != last_pat) chk("dec_hold", 32'(dec_pattern), 32'(last_pat));
            end
            last_pat = dec_pattern;

            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                logic [NREQ-1:0] oh;
                oh = '0;
                oh[rsp_q[0].id] = 1'b1;
                chk("rsp_valid", 32'(rsp_valid), 32'(oh));
                chk("rsp_id", 32'(rsp_id), 32'(rsp_q[0].id));
                chk("rsp_parity", 32'(rsp_parity), 32'(rsp_q[0].par));
                void'(rsp_q.pop_front());
                rsp_count++;
                last_rsp_cyc = cyc;
            end else if (rsp_valid != '0) begin
                chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end

            if (req_ready != '0) begin
                int   k;
                iss_t it;
                rsp_t rt;
                k = 0;
                chk("rdy_legal", 32'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
                for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) k = i;
                grant_log.push_back(k);
                it.pat = req_pattern[k*8 +: 8];
                it.cyc = cyc + 1;
                iss_q.push_back(it);
                rt.id  = k;
                rt.par = par_f(it.pat);
                rt.cyc = cyc + 2 + int'(DEC_LAT);
                rsp_q.push_back(rt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ready"}, 32'(req_ready), 32'd0);
        chk({pfx, "_dec_en"}, 32'(dec_en), 32'd0);
        chk({pfx, "_dec_pat"}, 32'(dec_pattern), 32'd0);
        chk({pfx, "_dec_vld"}, 32'(dec_valid_o), 32'd0);
        chk({pfx, "_rsp_vld"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({pfx, "_rsp_par"}, 32'(rsp_parity), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        req_valid = '0;
        inj = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   rc0;
        bit   done;
        rst_n = 1'b0;
        en = 1'b0;
        inj = 1'b0;
        req_valid = '1;
        req_pattern = '0;
        repeat (2) tick();
        @(negedge clk);
        chk_all_zero("rst");
        tick();
        rst_n = 1'b1;
        req_valid = '0;

        // Single request from requester 2; enable and valid together while IDLE.
        tick();
        en = 1'b1;
        req_valid = 4'b0100;
        req_pattern[2*8 +: 8] = 8'h5A;
        @(negedge clk);
        chk("idle_no_ready", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_dec_en", 32'(dec_en), 32'd1);
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        repeat (8) tick();

        // Round-robin fairness from a fresh pointer.
        do_reset();
        en = 1'b1;
        tick();
        for (int i = 0; i < int'(NREQ); i++) req_pattern[i*8 +: 8] = 8'($urandom);
        grant_log.delete();
        req_valid = '1;
        repeat (8) tick();
        req_valid = '0;
        chk("rr_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
        repeat (10) tick();

        // Drain with three transfers in flight; enable drops with the third accept.
        rc0 = rsp_count;
        req_pattern = 32'($urandom);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        en = 1'b0;
        tick();
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready != '0) chk("drain_ready", 32'(req_ready), 32'd0);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
        chk("drain_rsps", 32'(rsp_count - rc0), 32'd3);
        chk("busy_fall", 32'(cyc), 32'(last_rsp_cyc + 1));
        chk("idle_dec_en", 32'(dec_en), 32'd0);
        tick();
        req_valid = '0;

        // Re-enable during DRAIN: one low cycle, grants resume once back in RUN.
        en = 1'b1;
        tick();
        req_valid = 4'b0010;
        req_pattern[1*8 +: 8] = 8'($urandom);
        @(negedge clk);
        chk("re_ready0", 32'(req_ready), 32'b0010);
        tick();
        en = 1'b0;
        @(negedge clk);
        chk("re_ready1", 32'(req_ready), 32'b0010);
        tick();
        en = 1'b1;
        @(negedge clk);
        chk("re_drain_ready", 32'(req_ready), 32'd0);
        chk("re_drain_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        chk("re_resume", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        en = 1'b0;
        wait_idle("re");
        chk("re_sb_empty", 32'(rsp_q.size()), 32'd0);

        // Mismatch: decoder valid with nothing in flight.
        @(negedge clk);
        chk("err_before", 32'(err), 32'd0);
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("err_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset mid-stream with two patterns in flight.
        do_reset();
        @(negedge clk);
        chk("rst_clr_err", 32'(err), 32'd0);
        tick();
        en = 1'b1;
        tick();
        req_pattern = 32'($urandom);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        rst_n = 1'b0;
        req_valid = '0;
        iss_q.delete();
        rsp_q.delete();
        rc0 = rsp_count;
        tick();
        @(negedge clk);
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_count - rc0), 32'd0);
        chk("midrst_no_err", 32'(err), 32'd0);
        chk("sb_empty", 32'(iss_q.size() + rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming_dec_arb.md
# hamming_dec_arb

Round-robin scheduler that shares one `hamming_dec` instance between `NREQ` requesters. Accepts at most one pattern per cycle from the requesters, drives the decoder's enable, pattern and valid inputs, and tracks each issued pattern by requester ID through a fixed-latency tag pipeline. Routes each returned parity back to the requester that issued it. Sits between the ECC client ports and the single shared decoder in the ECC subsystem.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DEC_LAT`, 1: decoder latency in cycles, from `o_dec_valid` to `i_dec_valid`, ≥1.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `i_en`  in  1  scheduler enable; low stops new grants and drains in-flight work.
- `i_req_valid`  in  `NREQ`  per-requester pattern valid.
- `i_req_pattern`  in  `NREQ` x `pattern_t`  per-requester pattern.
- `o_req_ready`  out  `NREQ`  one-hot grant; a transfer happens when valid and ready are both high.
- `o_dec_en`  out  1  to decoder `i_en`.
- `o_dec_pattern`  out  `pattern_t`  to decoder `i_pattern`.
- `o_dec_valid`  out  1  to decoder `i_valid`.
- `i_dec_parity`  in  `parity_t`  from decoder `o_parity`.
- `i_dec_valid`  in  1  from decoder `o_valid`.
- `o_rsp_valid`  out  `NREQ`  one-hot response strobe.
- `o_rsp_id`  out  `req_id_t`  ID of the requester receiving the response.
- `o_rsp_parity`  out  `parity_t`  returned parity.
- `o_busy`  out  1  high when state ≠ IDLE.
- `o_err`  out  1  sticky tag/valid mismatch flag.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN when `i_en`=1.
  - RUN→DRAIN when `i_en`=0.
  - DRAIN→RUN when `i_en`=1.
  - DRAIN→IDLE when the issue register and all tag stages are empty and `i_en`=0.
- Grants are made only in RUN. `o_req_ready` is combinational: it is the highest-priority valid requester, starting from the round-robin pointer `rr_ptr`. Ready is never raised for a requester whose valid is low.
- On an accepted transfer to requester k, `rr_ptr` becomes (k+1) mod `NREQ`. With no transfer, `rr_ptr` holds.
- The accepted pattern and ID are registered. `o_dec_valid`=1 and `o_dec_pattern`=pattern on the next cycle; otherwise `o_dec_valid`=0 and `o_dec_pattern` holds its value.
- `o_dec_en`=1 in RUN and DRAIN, 0 in IDLE.
- Tag pipeline: `DEC_LAT` stages of {valid, ID}. It is loaded from the issue register in step with `o_dec_valid`.
- When the head stage is valid and `i_dec_valid`=1, the following are registered on the next cycle: `o_rsp_valid`[ID]=1, `o_rsp_id`=ID, `o_rsp_parity`=`i_dec_parity`.
- Mismatch (head valid without `i_dec_valid`, or `i_dec_valid` with head invalid):
  - `o_err` is set and stays set until reset.
  - No response is emitted; the head stage is discarded.
- Reset, including mid-operation:
  - State IDLE, `rr_ptr`=0, all tag stages invalid; in-flight work is dropped.
  - Every output is 0: `o_req_ready`, `o_dec_en`, `o_dec_pattern`, `o_dec_valid`, `o_rsp_valid`, `o_rsp_id`, `o_rsp_parity`, `o_busy`, `o_err`.

## Timing
- Accept (cycle T) → `o_dec_valid` at T+1 → `i_dec_valid` at T+1+`DEC_LAT` → `o_rsp_valid` at T+2+`DEC_LAT`.
- Throughput is one accept per cycle; back-to-back grants are allowed. Responses return in issue order.
- `i_en` falling at cycle T: no grant in T+1 onward. A transfer accepted in T still completes. `o_busy` falls the cycle after the last response is registered.
- `i_en` and a grant in the same cycle: the state at the clock edge decides; a grant in RUN in that cycle is valid.
- `i_en`=1 in IDLE: the first grant is possible in the cycle after, once the state is RUN.

## Structure
- Shared package, alongside `pattern_t` and `parity_t` in `define.sv`:
  - `req_id_t`, `$clog2(NREQ_MAX)` bits, with `NREQ_MAX`=16.
  - `arb_state_e` (IDLE, RUN, DRAIN).
- Natural sub-module: `rr_arbiter`. It takes `NREQ` requests and a pointer, and returns a one-hot grant plus an encoded ID. It is combinational and is reused by other ECC schedulers.
- The `hamming_dec` instance is not inside this block; the top level connects them.

## Test plan
- Single request: reset, `i_en`=1, requester 2 sends pattern 0x5A once, `DEC_LAT`=1 → `o_dec_valid` one cycle after accept; `o_rsp_valid`=4'b0100, `o_rsp_id`=2 three cycles after accept.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3, and responses arrive in the same ID order.
- Drain: 3 transfers in flight, `DEC_LAT`=3, then `i_en` dropped → no further ready; 3 responses; `o_busy` falls one cycle after the third response; `o_dec_en`=0 in IDLE.
- Re-enable during DRAIN: `i_en` low for 1 cycle then high → state returns to RUN; grants resume on the following cycle; no response is lost.
- Mismatch: inject `i_dec_valid`=1 with the tag pipeline empty → `o_err`=1 next cycle and stays 1; no `o_rsp_valid`.
- Reset mid-stream: assert `i_rst_n`=0 with 2 patterns in flight → all outputs 0 on the next cycle; no stale response after reset release.
